// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Round-robin arbiter that shares a single UART_TX transmitter among NREQ
// byte producers. Each grant captures one byte and that requester's parity
// settings, launches the frame with a one-cycle TX_DATA_VALID strobe, and
// tracks TX_BUSY so that only one frame is in flight at any time.
//
// Build option: define UART_ARB_TAG_EN to send a tag byte (TAG_BASE | sel)
// before the data byte on every grant. Both frames use the same parity
// settings. Without the macro each grant sends one frame.
//
// Ports
//   CLK            clock, rising edge
//   RST            asynchronous active-low reset
//   REQ            per-requester byte-pending level
//   REQ_DATA       byte of requester i at [8i+7:8i]
//   REQ_PAR_EN     per-requester parity enable
//   REQ_PAR_TYP    per-requester parity type (0 even, 1 odd)
//   ACK            one-cycle capture pulse to the granted requester
//   TX_BUSY        BUSY from UART_TX
//   TX_P_DATA      byte presented to UART_TX
//   TX_DATA_VALID  one-cycle launch strobe
//   TX_PAR_EN      parity enable of the current frame
//   TX_PAR_TYP     parity type of the current frame
//   GNT_ID         index of the current or last granted requester
//   ARB_BUSY       high from grant until the last frame of the grant is done
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a request while the transmitter is idle
// WAIT_BUSY | frame launched, waiting for TX_BUSY to rise
// WAIT_DONE | frame in progress, waiting for TX_BUSY to fall

module uart_tx_arbiter #(
  parameter int          NREQ     = 4,
  parameter int          IDW      = 2,
  parameter logic [7:0]  TAG_BASE = 8'hA0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [8*NREQ-1:0] REQ_DATA,
  input  logic [NREQ-1:0]   REQ_PAR_EN,
  input  logic [NREQ-1:0]   REQ_PAR_TYP,
  output logic [NREQ-1:0]   ACK,
  input  logic              TX_BUSY,
  output logic [7:0]        TX_P_DATA,
  output logic              TX_DATA_VALID,
  output logic              TX_PAR_EN,
  output logic              TX_PAR_TYP,
  output logic [IDW-1:0]    GNT_ID,
  output logic              ARB_BUSY
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

`ifdef UART_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  state_t         state;
  logic [IDW-1:0] ptr;

  logic           found;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] ptr_nxt;
  logic [7:0]     sel_byte;
  logic [7:0]     tag_byte;
  logic [7:0]     first_byte;

`ifdef UART_ARB_TAG_EN
  logic [7:0]     data_hold;
  logic           second_pending;
`endif

  // First set REQ bit at or above ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && REQ[(int'(ptr) + i) % NREQ]) begin
        found = 1'b1;
        sel   = IDW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  assign ptr_nxt    = IDW'((int'(sel) + 1) % NREQ);
  assign sel_byte   = REQ_DATA[8*int'(sel) +: 8];
  assign tag_byte   = TAG_BASE | 8'(sel);
  assign first_byte = TAG_EN ? tag_byte : sel_byte;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      ptr            <= '0;
      ACK            <= '0;
      TX_P_DATA      <= 8'h00;
      TX_DATA_VALID  <= 1'b0;
      TX_PAR_EN      <= 1'b0;
      TX_PAR_TYP     <= 1'b0;
      GNT_ID         <= '0;
      ARB_BUSY       <= 1'b0;
`ifdef UART_ARB_TAG_EN
      data_hold      <= 8'h00;
      second_pending <= 1'b0;
`endif
    end else begin
      ACK           <= '0;
      TX_DATA_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (found && !TX_BUSY) begin
            ACK           <= NREQ'(1) << sel;
            TX_P_DATA     <= first_byte;
            TX_PAR_EN     <= REQ_PAR_EN[sel];
            TX_PAR_TYP    <= REQ_PAR_TYP[sel];
            GNT_ID        <= sel;
            TX_DATA_VALID <= 1'b1;
            ARB_BUSY      <= 1'b1;
            ptr           <= ptr_nxt;
`ifdef UART_ARB_TAG_EN
            data_hold      <= sel_byte;
            second_pending <= 1'b1;
`endif
            state         <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (TX_BUSY) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!TX_BUSY) begin
`ifdef UART_ARB_TAG_EN
            if (second_pending) begin
              // Data frame follows the tag; parity settings are kept.
              TX_P_DATA      <= data_hold;
              TX_DATA_VALID  <= 1'b1;
              second_pending <= 1'b0;
              state          <= WAIT_BUSY;
            end else begin
              ARB_BUSY <= 1'b0;
              state    <= IDLE;
            end
`else
            ARB_BUSY <= 1'b0;
            state    <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural UART_TX busy
// model and a launch scoreboard. Build with UART_ARB_TAG_EN to exercise
// the tag-frame variant.

module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int FRAME_CYC = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_pe;
  logic [NREQ-1:0]   req_pt;
  logic [NREQ-1:0]   ack;
  logic              model_busy;
  logic              force_busy;
  logic              tx_busy;
  logic [7:0]        p_data;
  logic              valid;
  logic              par_en;
  logic              par_typ;
  logic [IDW-1:0]    gnt_id;
  logic              arb_busy;

  assign tx_busy = model_busy | force_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .TAG_BASE(8'hA0)) dut (
    .CLK(clk), .RST(rst_n), .REQ(req), .REQ_DATA(req_data),
    .REQ_PAR_EN(req_pe), .REQ_PAR_TYP(req_pt), .ACK(ack),
    .TX_BUSY(tx_busy), .TX_P_DATA(p_data), .TX_DATA_VALID(valid),
    .TX_PAR_EN(par_en), .TX_PAR_TYP(par_typ), .GNT_ID(gnt_id),
    .ARB_BUSY(arb_busy)
  );

  typedef struct packed {
    logic [7:0]      data;
    logic            pe;
    logic            pt;
    logic [IDW-1:0]  id;
    logic [NREQ-1:0] ack;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic launched = 1'b0;
  logic prev_busy = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_grant(input int id, input logic [7:0] data, input logic pe, input logic pt);
    exp_t e;
    e.pe  = pe;
    e.pt  = pt;
    e.id  = IDW'(id);
    e.ack = NREQ'(1) << id;
`ifdef UART_ARB_TAG_EN
    e.data = 8'hA0 | 8'(id);
    sb.push_back(e);
    e.ack  = '0;
`endif
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ack"},      32'(ack), 0);
    check_eq({tag, "_p_data"},   32'(p_data), 0);
    check_eq({tag, "_valid"},    32'(valid), 0);
    check_eq({tag, "_par_en"},   32'(par_en), 0);
    check_eq({tag, "_par_typ"},  32'(par_typ), 0);
    check_eq({tag, "_gnt_id"},   32'(gnt_id), 0);
    check_eq({tag, "_arb_busy"}, 32'(arb_busy), 0);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) break;
    end
    check_eq("sb_drain", sb.size(), 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (!arb_busy && !tx_busy) break;
    end
    check_eq("idle_reached", 32'(arb_busy | tx_busy), 0);
  endtask

  task automatic wait_ack_drop(input int budget);
    logic got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (ack != 0) begin
        req = req & ~ack;
        got = 1'b1;
        break;
      end
    end
    check_eq("ack_seen", 32'(got), 1);
  endtask

  task automatic wait_busy_level(input logic lvl, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (tx_busy == lvl) break;
    end
    check_eq("busy_level", 32'(tx_busy), 32'(lvl));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // UART_TX behaviour: BUSY rises one cycle after the launch, lasts FRAME_CYC.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (valid) begin
        @(posedge clk); #1 model_busy = 1'b1;
        repeat (FRAME_CYC) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  // Launch monitor and scoreboard consumer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_busy && !tx_busy) launched = 1'b0;
      prev_busy = tx_busy;
      if (valid) begin
        check_eq("launch_while_busy", 32'(tx_busy), 0);
        check_eq("double_launch", 32'(launched), 0);
        check_eq("arb_busy_at_launch", 32'(arb_busy), 1);
        launched = 1'b1;
        check_eq("sb_has_entry", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_eq("p_data", 32'(p_data), 32'(e.data));
          check_eq("par_en", 32'(par_en), 32'(e.pe));
          check_eq("par_typ", 32'(par_typ), 32'(e.pt));
          check_eq("gnt_id", 32'(gnt_id), 32'(e.id));
          check_eq("ack_at_launch", 32'(ack), 32'(e.ack));
        end
      end else if (ack != 0) begin
        check_eq("ack_without_launch", 32'(valid), 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    req        = '0;
    req_data   = '0;
    req_pe     = '0;
    req_pt     = '0;
    force_busy = 1'b0;

    // Reset state and quiet idle.
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check_eq("idle_no_launch", 32'(valid), 0);
    end

    // Single grant: latency, one-cycle strobes, ARB_BUSY release.
    req_data[7:0] = 8'hAB;
    req_pe[0]     = 1'b1;
    req_pt[0]     = 1'b0;
    expect_grant(0, 8'hAB, 1'b1, 1'b0);
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk); #1;
    check_eq("lat_valid", 32'(valid), 1);
    check_eq("lat_ack", 32'(ack), 32'h1);
    check_eq("lat_par_en", 32'(par_en), 1);
    req = '0;
    @(negedge clk); #1;
    check_eq("pulse_valid", 32'(valid), 0);
    check_eq("pulse_ack", 32'(ack), 0);
    wait_busy_level(1'b1, 20);
    wait_busy_level(1'b0, 20);
    check_eq("arb_busy_hold", 32'(arb_busy), 1);
`ifndef UART_ARB_TAG_EN
    @(negedge clk); #1;
    check_eq("arb_busy_fall", 32'(arb_busy), 0);
`endif
    drain(100);
    wait_idle();

    // Round robin with all requesters held high.
    do_reset();
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req_pe   = 4'b1010;
    req_pt   = 4'b0110;
    expect_grant(0, 8'h10, 1'b0, 1'b0);
    expect_grant(1, 8'h21, 1'b1, 1'b1);
    expect_grant(2, 8'h32, 1'b0, 1'b1);
    expect_grant(3, 8'h43, 1'b1, 1'b0);
    expect_grant(0, 8'h10, 1'b0, 1'b0);
    @(negedge clk);
    req = 4'b1111;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) break;
    end
    req = '0;
    check_eq("rr_drain", sb.size(), 0);
    wait_idle();

    // Transmitter busy blocks the grant.
    @(negedge clk);
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check_eq("blocked_ack", 32'(ack), 0);
      check_eq("blocked_valid", 32'(valid), 0);
    end
    expect_grant(2, 8'h32, 1'b0, 1'b1);
    force_busy = 1'b0;
    wait_ack_drop(20);
    check_eq("blocked_gnt", 32'(gnt_id), 2);
    drain(100);
    wait_idle();

    // Reset mid-frame, then the pointer restarts at 0.
    expect_grant(1, 8'h21, 1'b1, 1'b1);
    @(negedge clk);
    req = 4'b0010;
    wait_ack_drop(20);
    wait_busy_level(1'b1, 20);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
`ifdef UART_ARB_TAG_EN
    check_eq("tag_pending_dropped", sb.size(), 1);
    sb.delete();
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_grant(0, 8'h10, 1'b0, 1'b0);
    expect_grant(1, 8'h21, 1'b1, 1'b1);
    req = 4'b0011;
    wait_ack_drop(100);
    check_eq("post_rst_gnt0", 32'(gnt_id), 0);
    wait_ack_drop(100);
    check_eq("post_rst_gnt1", 32'(gnt_id), 1);
    drain(100);
    wait_idle();

`ifdef UART_ARB_TAG_EN
    // Tag frame followed by data frame under a single grant.
    begin
      int extra_ack = 0;
      req_data[23:16] = 8'h5C;
      req_pe[2]       = 1'b1;
      req_pt[2]       = 1'b1;
      expect_grant(2, 8'h5C, 1'b1, 1'b1);
      @(negedge clk);
      req = 4'b0100;
      wait_ack_drop(20);
      for (int i = 0; i < 100; i++) begin
        @(negedge clk); #1;
        if (sb.size() == 0) break;
        check_eq("tag_arb_busy", 32'(arb_busy), 1);
        if (ack != 0) extra_ack++;
      end
      check_eq("tag_drain", sb.size(), 0);
      check_eq("tag_single_ack", 32'(extra_ack), 0);
      wait_idle();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
